async_bridge_mc: RTL
====================

# async_bridge_mc

Multi-channel, parametrised successor to the single-channel async bridge. It accepts 2-phase (transition-signalled) read/write requests from NCH click-domain channels and synchronises each request into the AXI clock domain. Channels are arbitrated round-robin onto one AXI-side start/done command port, and each channel gets a 2-phase acknowledge with read data. It sits between the click-controller core (one channel per requester, e.g. MMU and DMA ports) and the AXI master.

## Interface
- NCH, 2, number of async request channels (1..8)
- ADDR_W, 32, address width
- DATA_W, 256, data width
- SYNC_STAGES, 2, flip-flop stages on each request line (2..4)
- TIMEOUT_CYCLES, 1024, watchdog limit; used only with TIMEOUT_EN
- clk  in  1  AXI-domain clock (ACLK)
- rst  in  1  reset, asynchronous, active-high
- async_req  in  NCH  per-channel 2-phase request; a toggle means a new command
- async_wr  in  NCH  1 = write, 0 = read; bundled data, stable while req != ack
- async_addr  in  NCH*ADDR_W  channel c occupies bits [c*ADDR_W +: ADDR_W]; bundled
- async_wdata  in  NCH*DATA_W  per-channel write data; bundled
- async_ack  out  NCH  per-channel 2-phase acknowledge
- async_rdata  out  NCH*DATA_W  per-channel read data; stable before the ack toggle
- async_err  out  NCH  per-channel timeout flag; valid with ack
- synced_wr_start  out  1  one-cycle write start pulse
- synced_wr_addr  out  ADDR_W; synced_wr_data  out  DATA_W
- axi_wr_done  in  1  write-complete pulse
- synced_rd_start  out  1  one-cycle read start pulse
- synced_rd_addr  out  ADDR_W
- axi_rd_done  in  1  read-complete pulse; axi_rd_data valid in the same cycle
- axi_rd_data  in  DATA_W
- busy  out  1  high outside IDLE

## Operation
- Each async_req[c] passes through SYNC_STAGES flip-flops, giving req_s[c]. Channel c is pending while req_s[c] != async_ack[c].
- Bundled async_* inputs are sampled only after their request has been synchronised. The async side holds them until ack.
- FSM states:
  - IDLE: if any channel is pending, the round-robin arbiter grants one, searching from (last_grant+1) mod NCH. The granted channel's addr/wdata/wr are latched into the synced_* registers, the grant is recorded, and the FSM goes to ISSUE.
  - ISSUE: exactly one cycle with synced_wr_start or synced_rd_start high, selected by the latched wr. Then go to WAIT.
  - WAIT: on the matching done (axi_wr_done for a write, axi_rd_done for a read), latch axi_rd_data into async_rdata[grant] (reads only; writes leave it unchanged), clear async_err[grant], and go to ACK. The non-matching done is ignored.
  - ACK: toggle async_ack[grant], set last_grant = grant, and go to IDLE.
- Only one AXI transaction is outstanding at a time. The address/data outputs hold their value until the next grant.
- Done pulses in IDLE or ISSUE are ignored. The AXI side must not return done in the same cycle as start.
- A channel whose request toggles again before it has been acked violates the protocol; behaviour is undefined.

## Timing
- Reset values: async_ack = 0, async_rdata = 0, async_err = 0, both start pulses 0, synced_* addr/data = 0, busy = 0, last_grant = NCH-1 (so channel 0 wins first), FSM = IDLE.
- Latency, with the FSM idle: a req toggle sampled at edge 0 produces the start pulse at edge SYNC_STAGES+2.
- Latency, done to ack: done sampled at edge k gives the ack toggle at edge k+2 (WAIT->ACK, then ACK toggles).
- Back-to-back: IDLE may grant in the cycle after ACK. Minimum spacing between start pulses is 4 cycles plus the AXI latency.
- Reset asserted mid-transaction aborts it with no ack. The async side must also be reset, so req=0 and the channel matches ack=0.

## Configuration
- TIMEOUT_EN defined: a counter clears on entry to WAIT and increments each WAIT cycle. When it reaches TIMEOUT_CYCLES with no done, the FSM sets async_err[grant]=1, leaves async_rdata unchanged and goes to ACK. A late done is then ignored because the FSM is no longer in WAIT.
- TIMEOUT_EN undefined: WAIT lasts indefinitely, async_err is tied to 0 and no counter logic is generated.

## Test plan
- NCH=2, channel 0 write to 0x1000 with data 0xA5..A5 -> synced_wr_start pulses at edge 4 with addr 0x1000 and that data; axi_wr_done 3 cycles later -> async_ack[0] toggles to 1 two cycles after done.
- Channel 1 read at 0x2000, axi_rd_data=0xDEAD_BEEF -> async_rdata[1]=0xDEAD_BEEF before async_ack[1] toggles; async_err[1]=0.
- Both channels toggle req in the same cycle, repeated 4 times -> grants alternate 0,1,0,1; each channel is acked exactly once per toggle.
- Channel 0 write outstanding, axi_rd_done pulses -> no ack; ack follows only axi_wr_done.
- TIMEOUT_EN with TIMEOUT_CYCLES=16, read never completes -> ack toggles with async_err=1 about 17 cycles after entering WAIT; a done arriving later changes nothing.
- rst asserted during WAIT -> all outputs return to 0 at once, busy=0; a fresh request after reset completes normally.

Source files
------------

// File: rtl/async_bridge_mc.sv
// async_bridge_mc: synchronises NCH 2-phase click-domain requests into the AXI clock domain,
// arbitrates them round-robin onto one start/done command port and returns a 2-phase ack
// with read data per channel.
// Optional feature: define TIMEOUT_EN to add a WAIT-state watchdog of TIMEOUT_CYCLES cycles
// that acks the channel with async_err set when the AXI side never answers.
module async_bridge_mc #(
    parameter int unsigned NCH            = 2,
    parameter int unsigned ADDR_W         = 32,
    parameter int unsigned DATA_W         = 256,
    parameter int unsigned SYNC_STAGES    = 2,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [NCH-1:0]        i_async_req,
    input  logic [NCH-1:0]        i_async_wr,
    input  logic [NCH*ADDR_W-1:0] i_async_addr,
    input  logic [NCH*DATA_W-1:0] i_async_wdata,
    output logic [NCH-1:0]        o_async_ack,
    output logic [NCH*DATA_W-1:0] o_async_rdata,
    output logic [NCH-1:0]        o_async_err,
    output logic                  o_synced_wr_start,
    output logic [ADDR_W-1:0]     o_synced_wr_addr,
    output logic [DATA_W-1:0]     o_synced_wr_data,
    input  logic                  i_axi_wr_done,
    output logic                  o_synced_rd_start,
    output logic [ADDR_W-1:0]     o_synced_rd_addr,
    input  logic                  i_axi_rd_done,
    input  logic [DATA_W-1:0]     i_axi_rd_data,
    output logic                  o_busy
);

    localparam int unsigned GW = (NCH > 1) ? $clog2(NCH) : 1;

    // Reject parameter values the design was never meant to handle.
    if (NCH < 1 || NCH > 8) begin : g_bad_nch
        $error("async_bridge_mc: NCH must be 1..8");
    end
    if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
        $error("async_bridge_mc: SYNC_STAGES must be 2..4");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_tmo
        $error("async_bridge_mc: TIMEOUT_CYCLES must be at least 1");
    end

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StAck} state_e;

    state_e                          r_state;
    state_e                          w_state_d;
    logic [SYNC_STAGES-1:0][NCH-1:0] r_sync;
    logic [NCH-1:0]                  w_req_s;
    logic [NCH-1:0]                  w_pend;
    logic [GW-1:0]                   w_pick;
    logic                            w_grant_en;
    logic                            w_done_en;
    logic [NCH-1:0][ADDR_W-1:0]      w_addr_arr;
    logic [NCH-1:0][DATA_W-1:0]      w_wdata_arr;
    logic [NCH-1:0][DATA_W-1:0]      r_rdata;
    logic [NCH-1:0]                  r_ack;
    logic [GW-1:0]                   r_grant;
    logic [GW-1:0]                   r_last;
    logic                            r_wr;
    logic [ADDR_W-1:0]               r_addr;
    logic [DATA_W-1:0]               r_wdata;
    logic                            r_wr_start;
    logic                            r_rd_start;

    // Nearest pending channel after 'last' in circular order; 'last' itself is searched last.
    function automatic logic [GW-1:0] rr_pick(input logic [NCH-1:0] pend,
                                              input logic [GW-1:0]  last);
        logic [GW-1:0] pick;
        int unsigned   idx;
        pick = last;
        // Walk from the farthest offset to the nearest so the nearest pending one wins.
        for (int unsigned off = NCH; off >= 1; off--) begin
            idx = (32'(last) + off) % NCH;
            if (pend[idx]) pick = GW'(idx);
        end
        return pick;
    endfunction

    assign w_addr_arr  = i_async_addr;
    assign w_wdata_arr = i_async_wdata;
    assign w_req_s     = r_sync[SYNC_STAGES-1];
    assign w_pend      = w_req_s ^ r_ack;
    assign w_pick      = rr_pick(w_pend, r_last);

    // Request synchronisers: only the req lines cross; bundled data is sampled after them.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sync <= '0;
        end else begin
            r_sync[0] <= i_async_req;
            for (int s = 1; s < int'(SYNC_STAGES); s++) begin
                r_sync[s] <= r_sync[s-1];
            end
        end
    end

`ifdef TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0]  r_tmo_cnt;
    logic           w_tmo_en;
    logic [NCH-1:0] r_err;
`endif

    // FSM state register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_d;
        end
    end

    // FSM next state and per-state control strobes.
    always_comb begin
        w_state_d  = r_state;
        w_grant_en = 1'b0;
        w_done_en  = 1'b0;
`ifdef TIMEOUT_EN
        w_tmo_en   = 1'b0;
`endif
        unique case (r_state)
            StIdle: begin
                if (|w_pend) begin
                    w_grant_en = 1'b1;
                    w_state_d  = StIssue;
                end
            end
            StIssue: begin
                w_state_d = StWait;
            end
            StWait: begin
                // Only the done matching the latched direction counts.
                if (r_wr ? i_axi_wr_done : i_axi_rd_done) begin
                    w_done_en = 1'b1;
                    w_state_d = StAck;
                end
`ifdef TIMEOUT_EN
                else if (r_tmo_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
                    w_tmo_en  = 1'b1;
                    w_state_d = StAck;
                end
`endif
            end
            StAck: begin
                w_state_d = StIdle;
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase
    end

    // Grant latch, start pulses, read-data capture and 2-phase ack toggling.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_grant    <= '0;
            r_last     <= GW'(NCH - 1);
            r_wr       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_wr_start <= 1'b0;
            r_rd_start <= 1'b0;
            r_rdata    <= '0;
            r_ack      <= '0;
        end else begin
            r_wr_start <= (r_state == StIssue) && r_wr;
            r_rd_start <= (r_state == StIssue) && !r_wr;
            if (w_grant_en) begin
                r_grant <= w_pick;
                r_wr    <= i_async_wr[w_pick];
                r_addr  <= w_addr_arr[w_pick];
                r_wdata <= w_wdata_arr[w_pick];
            end
            if (w_done_en && !r_wr) begin
                r_rdata[r_grant] <= i_axi_rd_data;
            end
            if (r_state == StAck) begin
                r_ack[r_grant] <= ~r_ack[r_grant];
                r_last         <= r_grant;
            end
        end
    end

`ifdef TIMEOUT_EN
    // Watchdog: cleared on the way into WAIT, counts every WAIT cycle; error flag per channel.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_tmo_cnt <= '0;
            r_err     <= '0;
        end else begin
            if (r_state == StIssue) begin
                r_tmo_cnt <= '0;
            end else if (r_state == StWait) begin
                r_tmo_cnt <= r_tmo_cnt + 1'b1;
            end
            if (w_done_en) begin
                r_err[r_grant] <= 1'b0;
            end else if (w_tmo_en) begin
                r_err[r_grant] <= 1'b1;
            end
        end
    end

    assign o_async_err = r_err;
`else
    assign o_async_err = '0;
`endif

    assign o_async_ack       = r_ack;
    assign o_async_rdata     = r_rdata;
    assign o_synced_wr_start = r_wr_start;
    assign o_synced_rd_start = r_rd_start;
    assign o_synced_wr_addr  = r_addr;
    assign o_synced_rd_addr  = r_addr;
    assign o_synced_wr_data  = r_wdata;
    assign o_busy            = (r_state != StIdle);

endmodule
